scsi_io_arbiter: RTL and testbench
==================================

# scsi_io_arbiter

- Sits between two SCSI target instances and the single io-controller sector port.
- Arbitrates their block read/write requests and presents one request at a time to the io controller, with the granted target's LBA and drive index.
- Routes the 512-byte sector buffer traffic and the ack strobe to the granted target only.
- Holds each grant from request issue through the falling edge of the io controller's ack.

## Interface
Parameters:
- DRIVE_BASE, 2'd0: drive index reported for target 0; target 1 reports DRIVE_BASE+1 (2-bit wrap).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- t_io_rd  in  2  per-target sector read request, bit n = target n
- t_io_wr  in  2  per-target sector write request
- t0_io_lba  in  32  target 0 block address
- t1_io_lba  in  32  target 1 block address
- t_io_ack  out  2  per-target ack; only the granted bit ever follows sd_ack
- t0_buff_din  in  8  target 0 buffer read data (sector write path)
- t1_buff_din  in  8  target 1 buffer read data
- t_buff_wr  out  2  per-target buffer write strobe
- t_buff_addr  out  9  buffer address, broadcast to both targets
- t_buff_dout  out  8  buffer write data, broadcast to both targets
- sd_rd  out  1  read request to io controller
- sd_wr  out  1  write request to io controller
- sd_lba  out  32  latched block address
- sd_drive  out  2  latched drive index
- sd_ack  in  1  io controller transfer-active strobe
- sd_buff_addr  in  9  io controller buffer address
- sd_buff_dout  in  8  io controller write data into target buffer
- sd_buff_din  out  8  data from granted target buffer
- sd_buff_wr  in  1  io controller buffer write strobe

## Operation
States:
- IDLE: no grant held.
- ISSUE: sd_rd or sd_wr held high until sd_ack is seen high.
- XFER: sd_ack high; buffer routed to the grant.
- RELEASE: one cycle after sd_ack falls.

Arbitration:
- A target is pending when t_io_rd[n] | t_io_wr[n].
- IDLE picks a pending target only while sd_ack==0.
- On pick:
  - Latch g, dir (rd wins if a target raises both), sd_lba, and sd_drive = DRIVE_BASE + g.
  - Set sd_rd or sd_wr.
  - Enter ISSUE.
- ISSUE: on sd_ack==1, clear sd_rd/sd_wr and enter XFER.
- XFER: on sd_ack==0, enter RELEASE.
- RELEASE: enter IDLE. This gives the target's buffer-select toggle and LBA increment a settled cycle before a re-grant.

Routing:
- t_io_ack[g] = sd_ack in ISSUE and XFER; 0 otherwise and for the non-granted target.
- t_buff_wr[g] = sd_buff_wr only in XFER; the other bit is 0.
- t_buff_addr and t_buff_dout are passthrough.
- sd_buff_din = g ? t1_buff_din : t0_buff_din, combinational mux. The target already registers its output.

Other rules:
- Requests dropped by a target before grant are simply not seen. A request dropped after grant is ignored; the grant runs to RELEASE.
- sd_lba, sd_drive and g hold from pick until the next pick.

## Timing
- Reset values: state IDLE; sd_rd=0, sd_wr=0, sd_lba=0, sd_drive=DRIVE_BASE, g=0; t_io_ack=0, t_buff_wr=0. Priority pointer = target 0.
- Request latency: pending seen in IDLE at cycle n → sd_rd/sd_wr high at n+1 (registered).
- ISSUE exit: sd_ack high at cycle m → sd_rd/sd_wr low at m+1.
- Ack routing is combinational, zero latency.
- Minimum gap between sd_ack falling and the next sd_rd/sd_wr: 2 cycles (RELEASE, IDLE pick).
- Both targets pending in the same cycle: resolved by priority (see Configuration). The loser stays pending and is granted after RELEASE.
- Reset mid-transfer: state returns to IDLE and outputs take reset values. A still-high sd_ack is not routed; no new request is issued until sd_ack is seen low.
- sd_ack rising while in IDLE or RELEASE (spurious): ignored, not routed, no state change.

## Configuration
- SCSI_ARB_RR_EN defined: round-robin. After every pick the priority pointer moves to the non-granted target, so with both continuously pending, grants alternate 0,1,0,1.
- Not defined: fixed priority; target 0 always wins a simultaneous request. The pointer is not implemented.

## Test plan
- Single read: t_io_rd=2'b10, t1_io_lba=0x1234 → next cycle sd_rd=1, sd_lba=0x1234, sd_drive=DRIVE_BASE+1. With sd_ack high for 512 cycles: t_io_ack=2'b10 throughout, t_buff_wr[1] mirrors sd_buff_wr, t_buff_wr[0]=0.
- Write path: t_io_wr=2'b01, io controller reads addr 0..511 → sd_wr=1 until sd_ack rises; sd_buff_din equals t0_buff_din each cycle; t_io_ack[1]=0.
- Simultaneous: t_io_rd=2'b11 held until each target's own ack:
  - Without the macro: grants in order 0 then 1.
  - With SCSI_ARB_RR_EN and both re-requesting four times: grant order 0,1,0,1.
- Gap: sd_ack falls at cycle k with another target pending → sd_rd high no earlier than k+2; sd_lba equals the new target's LBA.
- Reset mid-XFER: assert rst while sd_ack=1 → all outputs at reset values next cycle; no sd_rd/sd_wr until sd_ack has been seen 0, then a pending target is granted normally.
- Spurious ack: sd_ack pulse while in IDLE with no request → t_io_ack stays 2'b00, state stays IDLE.

Source files
------------

// File: rtl/scsi_io_arbiter.sv
// scsi_io_arbiter
//   Shares the single io-controller sector port between two SCSI targets.
//   One request at a time is presented to the io controller together with the
//   granted target's LBA and drive index; the ack strobe and the sector buffer
//   write strobe are routed to the granted target only. A grant is held from
//   request issue until one cycle after the io controller's ack falls.
//
// Configuration macro:
//   SCSI_ARB_RR_EN  defined   : round-robin between simultaneous requesters
//                   undefined : fixed priority, target 0 wins
//
// Parameters:
//   DRIVE_BASE   drive index for target 0; target 1 reports DRIVE_BASE+1 (wraps)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   t_io_rd/t_io_wr   [1:0]  per-target sector read/write requests
//   t0_io_lba/t1_io_lba      per-target block addresses
//   t_io_ack          [1:0]  per-target ack (granted bit follows sd_ack)
//   t0/t1_buff_din    [7:0]  per-target buffer read data
//   t_buff_wr         [1:0]  per-target buffer write strobe
//   t_buff_addr/t_buff_dout  buffer address / write data, broadcast
//   sd_rd/sd_wr              request to io controller (registered)
//   sd_lba/sd_drive          latched block address / drive index
//   sd_ack                   io controller transfer-active strobe
//   sd_buff_addr/dout/wr     io controller buffer address, data, strobe
//   sd_buff_din       [7:0]  data from the granted target's buffer
module scsi_io_arbiter #(
  parameter logic [1:0] DRIVE_BASE = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  t_io_rd,
  input  logic [1:0]  t_io_wr,
  input  logic [31:0] t0_io_lba,
  input  logic [31:0] t1_io_lba,
  output logic [1:0]  t_io_ack,
  input  logic [7:0]  t0_buff_din,
  input  logic [7:0]  t1_buff_din,
  output logic [1:0]  t_buff_wr,
  output logic [8:0]  t_buff_addr,
  output logic [7:0]  t_buff_dout,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_drive,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_RELEASE
  } state_t;

  state_t      state_q;
  logic        g_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] lba_q;
  logic [1:0]  drive_q;

  logic [1:0]  pend;
  logic        pick_d;
  logic        routed;
  logic        xfer;

`ifdef SCSI_ARB_RR_EN
  logic        ptr_q;
`endif

  // Winner among pending targets; only meaningful when pend is non-zero.
  always_comb begin
    pend = t_io_rd | t_io_wr;
`ifdef SCSI_ARB_RR_EN
    pick_d = (pend == 2'b11) ? ptr_q : ~pend[0];
`else
    pick_d = ~pend[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      lba_q   <= '0;
      drive_q <= DRIVE_BASE;
`ifdef SCSI_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // A still-high ack (e.g. left over from a reset mid-transfer)
          // blocks a new pick until the io controller has gone idle.
          if ((pend != 2'b00) && !sd_ack) begin
            g_q     <= pick_d;
            rd_q    <= t_io_rd[pick_d];
            wr_q    <= ~t_io_rd[pick_d];
            lba_q   <= pick_d ? t1_io_lba : t0_io_lba;
            drive_q <= DRIVE_BASE + {1'b0, pick_d};
`ifdef SCSI_ARB_RR_EN
            ptr_q   <= ~pick_d;
`endif
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sd_ack) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (!sd_ack) state_q <= S_RELEASE;
        end
        S_RELEASE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign routed = (state_q == S_ISSUE) || (state_q == S_XFER);
  assign xfer   = (state_q == S_XFER);

  assign t_io_ack    = {g_q & routed & sd_ack, ~g_q & routed & sd_ack};
  assign t_buff_wr   = {g_q & xfer & sd_buff_wr, ~g_q & xfer & sd_buff_wr};
  assign t_buff_addr = sd_buff_addr;
  assign t_buff_dout = sd_buff_dout;
  assign sd_buff_din = g_q ? t1_buff_din : t0_buff_din;

  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign sd_lba   = lba_q;
  assign sd_drive = drive_q;

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Testbench for scsi_io_arbiter: transaction-level reference model checked on
// every cycle, directed scenarios with literal expectations, then random
// traffic with random resets and spurious acks.
module tb_scsi_io_arbiter;

  localparam logic [1:0] DB = 2'd3;

  logic        clk;
  logic        rst;
  logic [1:0]  t_io_rd, t_io_wr;
  logic [31:0] t0_io_lba, t1_io_lba;
  logic [1:0]  t_io_ack;
  logic [7:0]  t0_buff_din, t1_buff_din;
  logic [1:0]  t_buff_wr;
  logic [8:0]  t_buff_addr;
  logic [7:0]  t_buff_dout;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic [1:0]  sd_drive;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  scsi_io_arbiter #(.DRIVE_BASE(DB)) dut (
    .clk(clk), .rst(rst),
    .t_io_rd(t_io_rd), .t_io_wr(t_io_wr),
    .t0_io_lba(t0_io_lba), .t1_io_lba(t1_io_lba),
    .t_io_ack(t_io_ack),
    .t0_buff_din(t0_buff_din), .t1_buff_din(t1_buff_din),
    .t_buff_wr(t_buff_wr), .t_buff_addr(t_buff_addr), .t_buff_dout(t_buff_dout),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_drive(sd_drive),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is "open" from pick until ack falls,
  // "acked" once the io controller has responded, followed by one rest cycle.
  logic        m_open, m_acked, m_rest;
  logic        m_g, m_rd, m_wr, m_prio;
  logic [31:0] m_lba;
  logic [1:0]  m_drive;
  logic [1:0]  m_pend;
  logic        m_win;

  assign m_pend = t_io_rd | t_io_wr;
  assign m_win  = (m_pend == 2'b11) ? m_prio : (m_pend == 2'b10);

  always @(posedge clk) begin
    if (rst) begin
      m_open <= 1'b0; m_acked <= 1'b0; m_rest <= 1'b0;
      m_g <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0; m_prio <= 1'b0;
      m_lba <= '0; m_drive <= DB;
    end else if (m_rest) begin
      m_rest <= 1'b0;
    end else if (m_open && !m_acked) begin
      if (sd_ack) begin
        m_acked <= 1'b1; m_rd <= 1'b0; m_wr <= 1'b0;
      end
    end else if (m_open) begin
      if (!sd_ack) begin
        m_open <= 1'b0; m_acked <= 1'b0; m_rest <= 1'b1;
      end
    end else if (m_pend != 2'b00 && !sd_ack) begin
      m_open  <= 1'b1;
      m_g     <= m_win;
      m_rd    <= t_io_rd[m_win];
      m_wr    <= !t_io_rd[m_win];
      m_lba   <= m_win ? t1_io_lba : t0_io_lba;
      m_drive <= DB + {1'b0, m_win};
`ifdef SCSI_ARB_RR_EN
      m_prio  <= !m_win;
`else
      m_prio  <= 1'b0;
`endif
    end
  end

  // Per-cycle comparison, after the negedge input changes have settled.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("sd_rd", {31'b0, sd_rd}, {31'b0, m_rd});
      chk("sd_wr", {31'b0, sd_wr}, {31'b0, m_wr});
      chk("sd_lba", sd_lba, m_lba);
      chk("sd_drive", {30'b0, sd_drive}, {30'b0, m_drive});
      chk("t_io_ack", {30'b0, t_io_ack},
          (m_open && sd_ack) ? (m_g ? 32'd2 : 32'd1) : 32'd0);
      chk("t_buff_wr", {30'b0, t_buff_wr},
          (m_open && m_acked && sd_buff_wr) ? (m_g ? 32'd2 : 32'd1) : 32'd0);
      chk("t_buff_addr", {23'b0, t_buff_addr}, {23'b0, sd_buff_addr});
      chk("t_buff_dout", {24'b0, t_buff_dout}, {24'b0, sd_buff_dout});
      chk("sd_buff_din", {24'b0, sd_buff_din},
          {24'b0, (m_g ? t1_buff_din : t0_buff_din)});
    end
  end

  // Bounded wait for a request, then one ack burst; reports the ack'd target.
  task automatic serve(input bit drop, output int gnt);
    int n;
    n = 0;
    gnt = -1;
    while (!(sd_rd || sd_wr) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL serve_timeout got=no_request exp=request t=%0t", $time);
      return;
    end
    sd_ack = 1'b1;
    #1;
    if (t_io_ack == 2'b10) gnt = 1;
    else if (t_io_ack == 2'b01) gnt = 0;
    if (drop && gnt == 1) begin t_io_rd[1] = 1'b0; t_io_wr[1] = 1'b0; end
    if (drop && gnt == 0) begin t_io_rd[0] = 1'b0; t_io_wr[0] = 1'b0; end
    repeat (3) @(negedge clk);
    sd_ack = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int g0, g1, gs[4];
    logic [7:0] d0;
    int ack_left;

    rst = 1'b1; t_io_rd = '0; t_io_wr = '0; t0_io_lba = '0; t1_io_lba = '0;
    t0_buff_din = '0; t1_buff_din = '0; sd_ack = 1'b0; sd_buff_addr = '0;
    sd_buff_dout = '0; sd_buff_wr = 1'b0;

    // Reset state
    @(negedge clk); chk_en = 1'b1; #3;
    chk("rst_sd_rd", {31'b0, sd_rd}, 32'd0);
    chk("rst_sd_wr", {31'b0, sd_wr}, 32'd0);
    chk("rst_sd_lba", sd_lba, 32'd0);
    chk("rst_sd_drive", {30'b0, sd_drive}, 32'd3);
    chk("rst_t_io_ack", {30'b0, t_io_ack}, 32'd0);
    chk("rst_t_buff_wr", {30'b0, t_buff_wr}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Single read from target 1; drive index wraps 3+1 -> 0
    t1_io_lba = 32'h1234; t0_io_lba = 32'hdead; t_io_rd = 2'b10;
    @(negedge clk); t_io_rd = 2'b00; #3;
    chk("rd_sd_rd", {31'b0, sd_rd}, 32'd1);
    chk("rd_sd_lba", sd_lba, 32'h1234);
    chk("rd_sd_drive", {30'b0, sd_drive}, 32'd0);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk); sd_ack = 1'b1; sd_buff_wr = 1'($urandom); #3;
      chk("rd_t_io_ack", {30'b0, t_io_ack}, 32'd2);
      if (i == 0) begin
        chk("rd_bw_issue", {30'b0, t_buff_wr}, 32'd0);
        chk("rd_sd_rd_held", {31'b0, sd_rd}, 32'd1);
      end else begin
        chk("rd_bw_xfer", {30'b0, t_buff_wr}, {30'b0, sd_buff_wr, 1'b0});
      end
      if (i == 1) chk("rd_sd_rd_drop", {31'b0, sd_rd}, 32'd0);
    end
    @(negedge clk); sd_ack = 1'b0; sd_buff_wr = 1'b0; #3;
    chk("rd_ack_off", {30'b0, t_io_ack}, 32'd0);
    repeat (2) @(negedge clk);

    // Write path from target 0
    t_io_wr = 2'b01; t0_io_lba = 32'habcd0001;
    @(negedge clk); t_io_wr = 2'b00; #3;
    chk("wr_sd_wr", {31'b0, sd_wr}, 32'd1);
    chk("wr_sd_rd", {31'b0, sd_rd}, 32'd0);
    chk("wr_sd_lba", sd_lba, 32'habcd0001);
    chk("wr_sd_drive", {30'b0, sd_drive}, 32'd3);
    @(negedge clk); #3;
    chk("wr_sd_wr_wait", {31'b0, sd_wr}, 32'd1);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      sd_ack = 1'b1; sd_buff_addr = 9'(i);
      d0 = 8'($urandom); t0_buff_din = d0; t1_buff_din = ~d0;
      #3;
      chk("wr_buff_din", {24'b0, sd_buff_din}, {24'b0, d0});
      chk("wr_ack1_low", {31'b0, t_io_ack[1]}, 32'd0);
      chk("wr_addr", {23'b0, t_buff_addr}, i);
    end
    @(negedge clk); sd_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous, each target drops after its own ack: 0 then 1
    pulse_rst();
    @(negedge clk); t_io_rd = 2'b11;
    serve(1'b1, g0);
    serve(1'b1, g1);
    chk("sim_first", g0, 32'd0);
    chk("sim_second", g1, 32'd1);
    repeat (3) @(negedge clk);

    // Both continuously pending
    pulse_rst();
    @(negedge clk); t_io_rd = 2'b11;
    for (int i = 0; i < 4; i++) serve(1'b0, gs[i]);
    t_io_rd = 2'b00;
    for (int i = 0; i < 4; i++) begin
`ifdef SCSI_ARB_RR_EN
      chk("cont_order", gs[i], i % 2);
`else
      chk("cont_order", gs[i], 32'd0);
`endif
    end
    repeat (3) @(negedge clk);

    // Gap after ack falls with the other target pending
    t_io_rd = 2'b01; t0_io_lba = 32'h100;
    @(negedge clk);
    sd_ack = 1'b1; t_io_rd = 2'b00; t_io_wr = 2'b10; t1_io_lba = 32'h200;
    repeat (2) @(negedge clk);
    @(negedge clk); sd_ack = 1'b0;
    @(negedge clk); #3; chk("gap_k1", {31'b0, sd_wr}, 32'd0);
    @(negedge clk); #3; chk("gap_k2", {31'b0, sd_wr}, 32'd0);
    @(negedge clk); #3;
    chk("gap_k3", {31'b0, sd_wr}, 32'd1);
    chk("gap_lba", sd_lba, 32'h200);
    chk("gap_drive", {30'b0, sd_drive}, 32'd0);
    @(negedge clk); sd_ack = 1'b1; t_io_wr = 2'b00;
    repeat (2) @(negedge clk);
    sd_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-transfer with ack still high
    t_io_rd = 2'b01; t0_io_lba = 32'h55aa;
    @(negedge clk); sd_ack = 1'b1;
    @(negedge clk); sd_buff_wr = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #3;
    chk("mrst_sd_rd", {31'b0, sd_rd}, 32'd0);
    chk("mrst_sd_lba", sd_lba, 32'd0);
    chk("mrst_sd_drive", {30'b0, sd_drive}, 32'd3);
    chk("mrst_t_io_ack", {30'b0, t_io_ack}, 32'd0);
    chk("mrst_t_buff_wr", {30'b0, t_buff_wr}, 32'd0);
    repeat (3) begin
      @(negedge clk); #3;
      chk("mrst_hold_rd", {31'b0, sd_rd}, 32'd0);
      chk("mrst_hold_ack", {30'b0, t_io_ack}, 32'd0);
    end
    @(negedge clk); sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(negedge clk); #3;
    chk("mrst_regrant", {31'b0, sd_rd}, 32'd1);
    chk("mrst_lba", sd_lba, 32'h55aa);
    serve(1'b1, g0);
    repeat (3) @(negedge clk);

    // Spurious ack while idle
    repeat (3) begin
      @(negedge clk); sd_ack = 1'b1; #3;
      chk("spur_ack", {30'b0, t_io_ack}, 32'd0);
      chk("spur_rd", {31'b0, sd_rd}, 32'd0);
    end
    @(negedge clk); sd_ack = 1'b0;
    @(negedge clk); t_io_wr = 2'b10;
    @(negedge clk); #3;
    chk("spur_then_req", {31'b0, sd_wr}, 32'd1);
    serve(1'b1, g0);
    repeat (3) @(negedge clk);

    // Random traffic
    ack_left = 0;
    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 5) == 0) t_io_rd[b] = ~t_io_rd[b];
        if ($urandom_range(0, 5) == 0) t_io_wr[b] = ~t_io_wr[b];
      end
      t0_io_lba = $urandom; t1_io_lba = $urandom;
      t0_buff_din = 8'($urandom); t1_buff_din = 8'($urandom);
      sd_buff_addr = 9'($urandom); sd_buff_dout = 8'($urandom);
      sd_buff_wr = 1'($urandom);
      if (sd_ack) begin
        ack_left--;
        if (ack_left <= 0) sd_ack = 1'b0;
      end else if ((sd_rd || sd_wr) && $urandom_range(0, 2) == 0) begin
        sd_ack = 1'b1; ack_left = $urandom_range(1, 6);
      end else if (!(sd_rd || sd_wr) && $urandom_range(0, 39) == 0) begin
        sd_ack = 1'b1; ack_left = $urandom_range(1, 3);
      end
    end

    @(negedge clk);
    rst = 1'b0; t_io_rd = '0; t_io_wr = '0; sd_ack = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
